// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing presets, per-axis timing struct and shared types
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] back;
        logic [15:0] active;
        logic [15:0] front;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{sync: 16'd96,  back: 16'd48, active: 16'd640, front: 16'd16};
    localparam vga_timing_t VGA_640X480_V = '{sync: 16'd2,   back: 16'd33, active: 16'd480, front: 16'd10};
    localparam vga_timing_t VGA_800X600_H = '{sync: 16'd128, back: 16'd88, active: 16'd800, front: 16'd40};
    localparam vga_timing_t VGA_800X600_V = '{sync: 16'd4,   back: 16'd23, active: 16'd600, front: 16'd1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_t;

    // Bars run white, yellow, cyan, green, magenta, red, blue, black: {r,g,b}
    function automatic logic [2:0] test_bar_rgb(input logic [2:0] bar);
        return {~bar[1], ~bar[2], ~bar[0]};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - run control, pixel request and video output bundle
interface vga_timing_gen_if #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 12
) ();
    logic              en;
    logic              busy;
    logic              req_valid;
    logic [CNT_W-1:0]  req_x;
    logic [CNT_W-1:0]  req_y;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] vga_rgb;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_de;
    logic              frame_start;
    logic              line_start;

    modport master (
        input  en, data_in,
        output busy, req_valid, req_x, req_y,
        output vga_rgb, vga_hs, vga_vs, vga_de, frame_start, line_start
    );

    modport slave (
        output en, data_in,
        input  busy, req_valid, req_x, req_y,
        input  vga_rgb, vga_hs, vga_vs, vga_de, frame_start, line_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping raster axis counter with sync/active decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480_H,
    parameter int          CNT_W  = 12
) (
    input  logic             rst_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] pos,
    output logic             at_last,
    output logic             sync_act,
    output logic             active
);
    localparam int ACT_LO = int'(TIMING.sync) + int'(TIMING.back);
    localparam int ACT_HI = ACT_LO + int'(TIMING.active);
    localparam int TOTAL  = ACT_HI + int'(TIMING.front);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt      = cnt_q;
    assign at_last  = (cnt_q == CNT_W'(TOTAL - 1));
    assign sync_act = (cnt_q < CNT_W'(TIMING.sync));
    assign active   = (cnt_q >= CNT_W'(ACT_LO)) && (cnt_q < CNT_W'(ACT_HI));
    assign pos      = active ? (cnt_q - CNT_W'(ACT_LO)) : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge rst_clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing and pixel output stage; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DATA_W   = 24,
    parameter int CNT_W    = 12,
    parameter int REQ_LAT  = 2
) (
    input  logic             rst_clk,
    input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             pattern_on,
`endif
    vga_timing_gen_if.master vif
);
    localparam vga_timing_t H_T = '{sync: 16'(H_SYNC), back: 16'(H_BACK),
                                    active: 16'(H_ACTIVE), front: 16'(H_FRONT)};
    localparam vga_timing_t V_T = '{sync: 16'(V_SYNC), back: 16'(V_BACK),
                                    active: 16'(V_ACTIVE), front: 16'(V_FRONT)};
`ifdef VGA_TEST_PATTERN_EN
    localparam int TAP_W = 5 + CNT_W;
`else
    localparam int TAP_W = 5;
`endif

    vga_state_t       state_q, state_d;
    logic             run;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_pos, v_pos;
    logic             h_last, v_last, h_sync, v_sync, h_act, v_act;

    assign run = (state_q == ST_RUN);

    vga_axis_counter #(.TIMING(H_T), .CNT_W(CNT_W)) u_h_cnt (
        .rst_clk (rst_clk), .rst (rst), .clr (!run), .inc (1'b1),
        .cnt (h_cnt), .pos (h_pos), .at_last (h_last), .sync_act (h_sync), .active (h_act)
    );

    vga_axis_counter #(.TIMING(V_T), .CNT_W(CNT_W)) u_v_cnt (
        .rst_clk (rst_clk), .rst (rst), .clr (!run), .inc (h_last),
        .cnt (v_cnt), .pos (v_pos), .at_last (v_last), .sync_act (v_sync), .active (v_act)
    );

    // A stop request only takes effect at the frame wrap, so frames never truncate
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (vif.en) state_d = ST_RUN;
            ST_RUN:  if (h_last && v_last && !vif.en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rst_clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign vif.busy      = run;
    assign vif.req_valid = run && h_act && v_act;
    assign vif.req_x     = vif.req_valid ? h_pos : '0;
    assign vif.req_y     = vif.req_valid ? v_pos : '0;

    // Tap word: {[x], hs, vs, de, frame_start, line_start}; tap[0] is the live counter view
    logic [TAP_W-1:0] tap [REQ_LAT+1];

`ifdef VGA_TEST_PATTERN_EN
    assign tap[0] = {vif.req_x, run && h_sync, run && v_sync, vif.req_valid,
                     run && (h_cnt == '0) && (v_cnt == '0), run && (h_cnt == '0)};
`else
    assign tap[0] = {run && h_sync, run && v_sync, vif.req_valid,
                     run && (h_cnt == '0) && (v_cnt == '0), run && (h_cnt == '0)};
`endif

    for (genvar i = 1; i <= REQ_LAT; i++) begin : g_dly
        logic [TAP_W-1:0] tap_d, tap_q;

        always_comb tap_d = tap[i-1];

        always_ff @(posedge rst_clk or posedge rst) begin
            if (rst) tap_q <= '0;
            else     tap_q <= tap_d;
        end

        assign tap[i] = tap_q;
    end

    logic [TAP_W-1:0]  tap_o;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] vga_rgb_d, vga_rgb_q;
    logic              vga_hs_d, vga_hs_q, vga_vs_d, vga_vs_q, vga_de_d, vga_de_q;
    logic              frame_start_d, frame_start_q, line_start_d, line_start_q;

    assign tap_o = tap[REQ_LAT];

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int CH_W  = DATA_W / 3;

    logic [CNT_W-1:0]  bar_idx;
    logic [2:0]        bar_rgb;
    logic [DATA_W-1:0] pat_rgb;

    // Driven from the delayed x so the bars line up with the delayed DE
    always_comb begin
        bar_idx = tap_o[TAP_W-1:5] / CNT_W'(BAR_W);
        bar_rgb = test_bar_rgb((bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0]);
        pat_rgb = '0;
        pat_rgb[3*CH_W-1:0] = {{CH_W{bar_rgb[2]}}, {CH_W{bar_rgb[1]}}, {CH_W{bar_rgb[0]}}};
    end
`endif

    always_comb begin
        pix = vif.data_in;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_on) pix = pat_rgb;
`endif
        vga_rgb_d     = tap_o[2] ? pix : '0;
        vga_hs_d      = tap_o[4] ? HS_POL : ~HS_POL;
        vga_vs_d      = tap_o[3] ? VS_POL : ~VS_POL;
        vga_de_d      = tap_o[2];
        frame_start_d = tap_o[1];
        line_start_d  = tap_o[0];
    end

    always_ff @(posedge rst_clk or posedge rst) begin
        if (rst) begin
            vga_rgb_q     <= '0;
            vga_hs_q      <= ~HS_POL;
            vga_vs_q      <= ~VS_POL;
            vga_de_q      <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            vga_rgb_q     <= vga_rgb_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_de_q      <= vga_de_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign vif.vga_rgb     = vga_rgb_q;
    assign vif.vga_hs      = vga_hs_q;
    assign vif.vga_vs      = vga_vs_q;
    assign vif.vga_de      = vga_de_q;
    assign vif.frame_start = frame_start_q;
    assign vif.line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - raster-position reference model checks for vga_timing_gen
module tb_vga_timing_gen;
    localparam int HS = 4, HB = 4, HA = 8, HF = 4;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int L  = 2;
    localparam int D  = L + 1;
    localparam int DW = 24;
    localparam int CW = 12;

    typedef struct {
        bit hs, vs, de, fs, ls;
        int x, y;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [DW-1:0] din = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic pattern_on = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_timing_gen_if #(.DATA_W(DW), .CNT_W(CW)) vif0 ();
    vga_timing_gen_if #(.DATA_W(DW), .CNT_W(CW)) vif1 ();

    assign vif0.en = en;
    assign vif1.en = en;
    assign vif0.data_in = din;
    assign vif1.data_in = din;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(DW), .CNT_W(CW), .REQ_LAT(L)
    ) dut0 (
        .rst_clk (clk),
        .rst     (rst),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_on (pattern_on),
`endif
        .vif     (vif0)
    );

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(DW), .CNT_W(CW), .REQ_LAT(L)
    ) dut1 (
        .rst_clk (clk),
        .rst     (rst),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_on (pattern_on),
`endif
        .vif     (vif1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_run = 0;
    int m_pos = 0;
    snap_t hist [8];
    logic [DW-1:0] din_h [2];
    int mode_h [2];
    logic [DW-1:0] src [3];
    int mode = 0;
    int cyc = 0;
    int n_de = 0, n_hs_low = 0, n_fs = 0, n_ls = 0;
    int last_fs = -1, fs_gap = 0;
    logic [DW-1:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        m_run = 0;
        m_pos = 0;
        for (int i = 0; i < 8; i++) hist[i] = '{0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 2; i++) begin din_h[i] = '0; mode_h[i] = 0; end
        for (int i = 0; i < 3; i++) src[i] = '0;
    endtask

    task automatic step();
        int hh, vv;
        logic [DW-1:0] d, exp_rgb;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_run = 0;
            m_pos = 0;
        end else if (m_run == 0) begin
            m_run = en ? 1 : 0;
            m_pos = 0;
        end else begin
            if (m_pos == FT - 1 && !en) m_run = 0;
            m_pos = (m_pos + 1) % FT;
        end
        hh = m_pos % HT;
        vv = m_pos / HT;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0].de = (m_run == 1) && hh >= HS + HB && hh < HS + HB + HA
                     && vv >= VS + VB && vv < VS + VB + VA;
        hist[0].hs = (m_run == 1) && hh < HS;
        hist[0].vs = (m_run == 1) && vv < VS;
        hist[0].fs = (m_run == 1) && m_pos == 0;
        hist[0].ls = (m_run == 1) && hh == 0;
        hist[0].x  = hist[0].de ? hh - (HS + HB) : 0;
        hist[0].y  = hist[0].de ? vv - (VS + VB) : 0;
        din_h[1]  = din_h[0];
        mode_h[1] = mode_h[0];

        chk("req_valid", vif0.req_valid, hist[0].de);
        chk("req_x", vif0.req_x, hist[0].x);
        chk("req_y", vif0.req_y, hist[0].y);
        chk("busy", vif0.busy, m_run);

        if (!hist[D].de)         exp_rgb = '0;
        else if (mode_h[1] == 2) exp_rgb = bars[hist[D].x / (HA / 8)];
        else if (mode_h[1] == 0) exp_rgb = {12'(hist[D].y), 12'(hist[D].x)};
        else                     exp_rgb = din_h[1];

        chk("vga_hs", vif0.vga_hs, !hist[D].hs);
        chk("vga_vs", vif0.vga_vs, !hist[D].vs);
        chk("vga_de", vif0.vga_de, hist[D].de);
        chk("frame_start", vif0.frame_start, hist[D].fs);
        chk("line_start", vif0.line_start, hist[D].ls);
        chk("vga_rgb", vif0.vga_rgb, exp_rgb);
        chk("pol1_hs", vif1.vga_hs, hist[D].hs);
        chk("pol1_vs", vif1.vga_vs, hist[D].vs);
        chk("pol1_de", vif1.vga_de, hist[D].de);
        chk("pol1_rgb", vif1.vga_rgb, exp_rgb);

        n_de     += int'(vif0.vga_de);
        n_hs_low += int'(!vif0.vga_hs);
        n_ls     += int'(vif0.line_start);
        if (vif0.frame_start) begin
            n_fs++;
            if (last_fs >= 0) fs_gap = cyc - last_fs;
            last_fs = cyc;
        end

        // Pipelined source: returns {y,x} of the request seen two cycles earlier
        src[2] = src[1];
        src[1] = src[0];
        src[0] = {vif0.req_y, vif0.req_x};
        d = (mode == 0) ? src[2] : DW'($urandom);
        din       = d;
        din_h[0]  = d;
        mode_h[0] = mode;
`ifdef VGA_TEST_PATTERN_EN
        pattern_on = (mode == 2);
`endif
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("arst_hs", vif0.vga_hs, 1);
        chk("arst_vs", vif0.vga_vs, 1);
        chk("arst_de", vif0.vga_de, 0);
        chk("arst_rgb", vif0.vga_rgb, 0);
        chk("arst_fs", vif0.frame_start, 0);
        chk("arst_ls", vif0.line_start, 0);
        chk("arst_busy", vif0.busy, 0);
        chk("arst_req", vif0.req_valid, 0);
        chk("arst_pol1_hs", vif1.vga_hs, 0);
        chk("arst_pol1_vs", vif1.vga_vs, 0);
        clear_model();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        clear_model();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 10; i++) step();
        n_de = 0; n_hs_low = 0; n_fs = 0; n_ls = 0;
        for (int i = 0; i < FT; i++) step();
        chk("de_per_frame", n_de, VA * HA);
        chk("hs_low_per_frame", n_hs_low, VT * HS);
        chk("fs_per_frame", n_fs, 1);
        chk("ls_per_frame", n_ls, VT);
        for (int i = 0; i < 240; i++) step();
        chk("fs_gap", fs_gap, FT);

        k = 0;
        while (!(m_run == 1 && m_pos == 50) && k < 2 * FT) begin step(); k++; end
        en = 1'b0;
        k = 0;
        do begin step(); k++; end while (vif0.busy && k < 2 * FT);
        chk("busy_fall_after_drop", k, FT - 50);
        for (int i = 0; i < 8; i++) step();
        chk("idle_hs", vif0.vga_hs, 1);
        chk("idle_de", vif0.vga_de, 0);

        en = 1'b1;
        k = 0;
        while (!(m_run == 1 && m_pos == 120) && k < 2 * FT) begin step(); k++; end
        do_reset();
        en = 1'b1;
        k = 0;
        do begin step(); k++; end while (!vif0.frame_start && k < 50);
        chk("fs_latency_after_restart", k, L + 2);

        mode = 1;
        for (int i = 0; i < 2500; i++) begin
            step();
            en = ($urandom_range(0, 99) < 96);
        end

`ifdef VGA_TEST_PATTERN_EN
        mode = 2;
        en = 1'b1;
        for (int i = 0; i < 450; i++) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
